// File: rtl/sma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sma_pkg
// Description : Shared types and constants for the SMA pulse generator:
//               FSM state encoding, register word addresses, CTRL bit map.
// Revision    : 1.0 - initial release
// ============================================================================
package sma_pkg;

    // Burst sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Avalon word addresses of the register file
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_HIGH   = 2'd1;
    localparam logic [1:0] ADDR_LOW    = 2'd2;
    localparam logic [1:0] ADDR_NPULSE = 2'd3;

    // CTRL register bit positions
    localparam int EN_BIT   = 0;
    localparam int CONT_BIT = 1;

endpackage : sma_pkg
`default_nettype wire

// File: rtl/sma_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : sma_pulse_timer
// Description : Loadable down-counter timing one phase (HIGH or LOW) of the
//               pulse train. Terminal count flags the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sma_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Phases are loaded with at least 1, so a value of 1 marks the final cycle
    assign count = r_count;
    assign tc    = (r_count == CNT_W'(1));

endmodule : sma_pulse_timer
`default_nettype wire

// File: rtl/sma_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : sma_pulse_gen
// Description : Trigger-driven programmable pulse-train generator for the SMA
//               connector. A rising edge on trig_in fires a burst of pulses
//               whose high time, low time and count are set over a
//               zero-wait-state Avalon-MM slave.
// Revision    : 1.0 - initial release
// ============================================================================
module sma_pulse_gen
    import sma_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pulse_out,
    output logic        busy
);

    // Programming registers
    logic             r_en;
    logic             r_cont;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;
    logic [CNT_W-1:0] r_npulses;

    // Burst state
    state_t           r_state;
    logic             r_trig_q;
    logic             r_pulse;
    logic             r_busy;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_high_lat;
    logic [CNT_W-1:0] r_low_lat;

    // Combinational helpers
    logic             w_wr;
    logic             w_start;
    logic             w_abort;
    logic             w_empty_burst;
    logic [CNT_W-1:0] w_rem_dec;
    logic             w_continue;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tc;
    logic [CNT_W-1:0] w_unused_tmr_count;

    // A programmed length of zero still occupies one cycle
    function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign w_wr          = chipselect && !write_n;
    // Enable is the pre-write value, so a same-cycle CTRL write cannot gate start
    assign w_start       = trig_in && !r_trig_q && r_en && (r_state == IDLE);
    assign w_abort       = w_wr && (address == ADDR_CTRL) && !writedata[EN_BIT]
                           && (r_state != IDLE);
    assign w_empty_burst = (r_npulses == '0) && !r_cont;
    // Remaining count saturates at zero so continuous runs never wrap
    assign w_rem_dec     = (r_rem == '0) ? '0 : (r_rem - 1'b1);
    assign w_continue    = r_cont || (w_rem_dec != '0);

    // Timer is reloaded at every phase boundary, picking the next phase length
    assign w_tmr_load = w_start
                     || ((r_state == HIGH) && w_tc)
                     || ((r_state == LOW)  && w_tc && w_continue);
    assign w_tmr_val  = w_start            ? max1(r_high) :
                        (r_state == HIGH)  ? r_low_lat    : r_high_lat;
    assign w_tmr_en   = (r_state != IDLE);

    sma_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .en       (w_tmr_en),
        .load_val (w_tmr_val),
        .count    (w_unused_tmr_count),
        .tc       (w_tc)
    );

    // Register file writes; bits above each field width are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_cont    <= 1'b0;
            r_high    <= '0;
            r_low     <= '0;
            r_npulses <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_CTRL: begin
                    r_en   <= writedata[EN_BIT];
                    r_cont <= writedata[CONT_BIT];
                end
                ADDR_HIGH:   r_high    <= writedata[CNT_W-1:0];
                ADDR_LOW:    r_low     <= writedata[CNT_W-1:0];
                ADDR_NPULSE: r_npulses <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Burst sequencer: start latches the programming, abort wins over phase steps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_trig_q   <= 1'b0;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_rem      <= '0;
            r_high_lat <= '0;
            r_low_lat  <= '0;
        end else begin
            r_trig_q <= trig_in;
            if (w_start) begin
                r_high_lat <= max1(r_high);
                r_low_lat  <= max1(r_low);
                r_rem      <= r_npulses;
                r_busy     <= 1'b1;
                if (w_empty_burst) begin
                    // Accepted but empty: busy for one cycle, no pulse
                    r_state <= IDLE;
                    r_pulse <= 1'b0;
                end else begin
                    r_state <= HIGH;
                    r_pulse <= 1'b1;
                end
            end else if (w_abort) begin
                r_state <= IDLE;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    HIGH: begin
                        if (w_tc) begin
                            r_state <= LOW;
                            r_pulse <= 1'b0;
                        end
                    end
                    LOW: begin
                        if (w_tc) begin
                            r_rem <= w_rem_dec;
                            if (w_continue) begin
                                r_state <= HIGH;
                                r_pulse <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;

    // Zero-wait read mux; address 3 reports live burst status
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_CTRL: begin
                    readdata[EN_BIT]   = r_en;
                    readdata[CONT_BIT] = r_cont;
                end
                ADDR_HIGH:   readdata[CNT_W-1:0] = r_high;
                ADDR_LOW:    readdata[CNT_W-1:0] = r_low;
                ADDR_NPULSE: begin
                    readdata[CNT_W-1:0] = r_rem;
                    readdata[31]        = r_busy;
                end
                default: ;
            endcase
        end
    end

    // Upper write-data bits have no destination when the fields are narrow
    generate
        if (CNT_W < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:CNT_W];
        end
    endgenerate

endmodule : sma_pulse_gen
`default_nettype wire

// File: tb/tb_sma_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sma_pulse_gen
// Description : Self-checking bench for sma_pulse_gen. A burst-level model
//               predicts pulse_out, busy and readdata from the cycle offset
//               into the current burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sma_pulse_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig_in = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        pulse_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    sma_pulse_gen #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .trig_in    (trig_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pulse_out  (pulse_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- burst-level reference model ----------------
    bit          m_en, m_cont, m_trigq, m_active, m_busy1;
    logic [15:0] m_high, m_low, m_np;
    int unsigned m_H, m_L, m_N, m_k, m_rem_hold;

    function automatic int unsigned rem_at(input int unsigned k);
        int unsigned q;
        q = k / (m_H + m_L);
        return (q >= m_N) ? 0 : (m_N - q);
    endfunction

    function automatic bit exp_pulse();
        return m_active && ((m_k % (m_H + m_L)) < m_H);
    endfunction

    function automatic bit exp_busy();
        return m_active || m_busy1;
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        int unsigned rem;
        r = 32'd0;
        rem = m_active ? rem_at(m_k) : m_rem_hold;
        if (chipselect) begin
            case (address)
                2'd0: r = {30'd0, m_cont, m_en};
                2'd1: r = {16'd0, m_high};
                2'd2: r = {16'd0, m_low};
                default: r = {exp_busy(), 15'd0, rem[15:0]};
            endcase
        end
        return r;
    endfunction

    task automatic model_edge();
        bit wr, start;
        if (reset) begin
            m_en = 0; m_cont = 0; m_trigq = 0; m_active = 0; m_busy1 = 0;
            m_high = 0; m_low = 0; m_np = 0; m_rem_hold = 0; m_k = 0;
            m_H = 1; m_L = 1; m_N = 0;
            return;
        end
        wr    = chipselect && !write_n;
        start = trig_in && !m_trigq && m_en && !m_active;
        m_busy1 = 0;
        if (start) begin
            m_H = (m_high == 0) ? 1 : m_high;
            m_L = (m_low == 0) ? 1 : m_low;
            m_N = m_np;
            m_k = 0;
            if (m_np == 0 && !m_cont) begin
                m_busy1 = 1;
                m_rem_hold = 0;
            end else begin
                m_active = 1;
            end
        end else if (m_active) begin
            if (wr && address == 2'd0 && !writedata[0]) begin
                m_rem_hold = rem_at(m_k);
                m_active = 0;
            end else begin
                m_k++;
                if ((m_k % (m_H + m_L)) == 0 && rem_at(m_k) == 0 && !m_cont) begin
                    m_active = 0;
                    m_rem_hold = 0;
                end
            end
        end
        m_trigq = trig_in;
        if (wr) begin
            case (address)
                2'd0: begin m_en = writedata[0]; m_cont = writedata[1]; end
                2'd1: m_high = writedata[15:0];
                2'd2: m_low  = writedata[15:0];
                default: m_np = writedata[15:0];
            endcase
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance model at the edge, compare outputs 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("pulse_out", {31'd0, pulse_out}, {31'd0, exp_pulse()});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy()});
        chk("readdata", readdata, exp_rd());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
    endtask

    task automatic cfg(input int h, input int l, input int n, input int ctrl);
        wr(2'd1, {16'hA5A5, 16'(h)});
        wr(2'd2, {16'h5A5A, 16'(l)});
        wr(2'd3, {16'hFFFF, 16'(n)});
        wr(2'd0, 32'(ctrl));
    endtask

    // Drive trig_in low for one cycle, then high; the next tick samples the edge
    task automatic arm();
        trig_in = 1'b0;
        tick();
        trig_in = 1'b1;
    endtask

    int hi, bz;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_pulse", {31'd0, pulse_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            chipselect = 1'b1; address = 2'(a);
            #1;
            chk("rst_read", readdata, 32'd0);
        end
        chipselect = 1'b0;
        tick();

        // Basic burst H=3 L=2 N=2, with an ignored second edge mid-burst
        cfg(3, 2, 2, 1);
        arm();
        chipselect = 1'b1; address = 2'd3;
        hi = 0; bz = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) trig_in = 1'b0;
            if (i == 3) trig_in = 1'b1;
            tick();
            hi += int'(pulse_out); bz += int'(busy);
            if (i == 5) chk("status_mid", readdata, 32'h8000_0001);
        end
        chk("basic_high_cycles", 32'(hi), 32'd6);
        chk("basic_busy_cycles", 32'(bz), 32'd10);
        chk("status_end", readdata, 32'h0000_0000);
        chipselect = 1'b0;

        // Zero high/low lengths: toggles every cycle
        cfg(0, 0, 4, 1);
        arm();
        hi = 0; bz = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(pulse_out); bz += int'(busy);
        end
        chk("zero_len_high", 32'(hi), 32'd4);
        chk("zero_len_busy", 32'(bz), 32'd8);

        // Continuous 10-cycle period, then disable mid-HIGH
        cfg(5, 5, 0, 3);
        arm();
        hi = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i < 20) hi += int'(pulse_out);
        end
        chk("cont_high", 32'(hi), 32'd10);
        chk("cont_in_high", {31'd0, pulse_out}, 32'd1);
        wr(2'd0, 32'd0);
        chk("abort_pulse", {31'd0, pulse_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // Rewriting HIGH mid-burst only affects the next burst
        cfg(3, 2, 2, 1);
        arm();
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'd9; end
            else begin chipselect = 1'b0; write_n = 1'b1; end
            tick();
            hi += int'(pulse_out);
        end
        chipselect = 1'b0; write_n = 1'b1;
        chk("old_width_high", 32'(hi), 32'd6);
        arm();
        hi = 0; bz = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            hi += int'(pulse_out); bz += int'(busy);
        end
        chk("new_width_high", 32'(hi), 32'd18);
        chk("new_width_busy", 32'(bz), 32'd22);

        // Reset mid-HIGH; trigger ignored until CTRL rewritten
        arm();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_pulse", {31'd0, pulse_out}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        arm();
        bz = 0;
        for (int i = 0; i < 5; i++) begin tick(); bz += int'(busy); end
        chk("post_rst_idle", 32'(bz), 32'd0);
        // Enable with all-zero counts: empty burst, one busy cycle
        wr(2'd0, 32'd1);
        arm();
        hi = 0; bz = 0;
        for (int i = 0; i < 4; i++) begin tick(); hi += int'(pulse_out); bz += int'(busy); end
        chk("empty_busy", 32'(bz), 32'd1);
        chk("empty_pulse", 32'(hi), 32'd0);

        // Enable written in the same cycle as the edge: old enable gates start
        cfg(2, 1, 1, 0);
        trig_in = 1'b0;
        tick();
        trig_in = 1'b1;
        wr(2'd0, 32'd1);
        bz = 0;
        for (int i = 0; i < 4; i++) begin tick(); bz += int'(busy); end
        chk("old_en_gates", 32'(bz), 32'd0);
        arm();
        bz = 0;
        for (int i = 0; i < 5; i++) begin tick(); bz += int'(busy); end
        chk("fresh_edge_starts", 32'(bz), 32'd3);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
            chipselect = $urandom_range(0, 1);
            address = 2'($urandom_range(0, 3));
            write_n = ($urandom_range(0, 9) != 0);
            if (address == 2'd0)
                writedata = {$urandom_range(0, 65535), 14'd0, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) != 0)};
            else
                writedata = {16'($urandom), 16'($urandom_range(0, 4))};
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sma_pulse_gen
`default_nettype wire
